// File: rtl/conv_mac_seq_if.sv
// Start/busy/done handshake bundle for conv_mac_seq: window/filter operands in, pixel out.
// Element k of image/filter sits at bits DATA_WIDTH*k +: DATA_WIDTH (element 0 leftmost).
interface conv_mac_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 9
);
    logic                      start;
    logic [0:N*DATA_WIDTH-1]   image;
    logic [0:N*DATA_WIDTH-1]   filter;
    logic                      busy;
    logic                      done;
    logic [0:DATA_WIDTH-1]     result;

    modport master (output start, image, filter, input busy, done, result);
    modport slave  (input start, image, filter, output busy, done, result);
endinterface

// File: rtl/conv_mac_seq.sv
// Sequential signed convolution MAC: one element per cycle, rescale by FRAC_BITS, saturate.
// Optional macro CONV_RELU_EN clamps negative rescaled sums to zero before saturation.
//
// state  | meaning
// S_IDLE | waiting for start
// S_MAC  | accumulating elements 0..N-1, busy high
// S_DONE | result valid, done pulse; start here chains the next convolution
module conv_mac_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int D          = 1,
    parameter int F          = 3,
    parameter int ACC_WIDTH  = 24,
    parameter int FRAC_BITS  = 0
) (
    input  logic           clk,
    input  logic           reset,
    conv_mac_seq_if.slave  bus
);
    localparam int N     = D * F * F;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [0:N*DATA_WIDTH-1]        r_img;
    logic [0:N*DATA_WIDTH-1]        r_flt;
    logic [IDX_W-1:0]               r_idx;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic [DATA_WIDTH-1:0]          r_result;

    logic                           w_accept;
    logic                           w_last;
    logic signed [DATA_WIDTH-1:0]   w_img_el;
    logic signed [DATA_WIDTH-1:0]   w_flt_el;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_scaled;
    logic signed [ACC_WIDTH-1:0]    w_clip_in;
    logic [DATA_WIDTH-1:0]          w_sat;

    assign w_accept = bus.start && (r_state != S_MAC);
    assign w_last   = (r_state == S_MAC) && (r_idx == IDX_W'(N - 1));

    assign w_img_el   = r_img[DATA_WIDTH*r_idx +: DATA_WIDTH];
    assign w_flt_el   = r_flt[DATA_WIDTH*r_idx +: DATA_WIDTH];
    assign w_prod     = w_img_el * w_flt_el;
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_scaled   = w_sum >>> FRAC_BITS;

`ifdef CONV_RELU_EN
    assign w_clip_in = w_scaled[ACC_WIDTH-1] ? '0 : w_scaled;
`else
    assign w_clip_in = w_scaled;
`endif

    always_comb begin
        w_sat = w_clip_in[DATA_WIDTH-1:0];
        if (w_clip_in > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_clip_in < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_MAC;
            S_MAC:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.start ? S_MAC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands are frozen at acceptance so upstream may move on immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_img    <= '0;
            r_flt    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_img <= bus.image;
            r_flt <= bus.filter;
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_sum;
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
                r_result <= w_sat;
            end
        end
    end

    assign bus.busy   = (r_state == S_MAC);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
endmodule

// File: tb/tb_conv_mac_seq.sv
// Self-checking bench for conv_mac_seq: two instances (FRAC_BITS 0 and 2) driven in parallel.
module tb_conv_mac_seq;
    localparam int DW  = 8;
    localparam int N   = 9;
    localparam int ACC = 24;

    if (ACC < 2*DW + $clog2(N)) begin : g_acc_rule
        $error("ACC_WIDTH too narrow for full-precision accumulation");
    end

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tb_start = 1'b0;
    logic [0:N*DW-1] tb_img = '0;
    logic [0:N*DW-1] tb_flt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    conv_mac_seq_if #(.DATA_WIDTH(DW), .N(N)) bus0 ();
    conv_mac_seq_if #(.DATA_WIDTH(DW), .N(N)) bus1 ();

    assign bus0.start  = tb_start;
    assign bus0.image  = tb_img;
    assign bus0.filter = tb_flt;
    assign bus1.start  = tb_start;
    assign bus1.image  = tb_img;
    assign bus1.filter = tb_flt;

    conv_mac_seq #(.DATA_WIDTH(DW), .D(1), .F(3), .ACC_WIDTH(ACC), .FRAC_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    conv_mac_seq #(.DATA_WIDTH(DW), .D(1), .F(3), .ACC_WIDTH(ACC), .FRAC_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int iv;
        int fv;
        int e0;
        int e1;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer dot product, floor shift, optional ReLU, clamp.
    function automatic int ref_conv(input int im[N], input int fl[N], input int frac);
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(im[k]) * longint'(fl[k]);
        s = s >>> frac;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    function automatic logic [0:N*DW-1] pack(input int v[N]);
        logic [0:N*DW-1] p;
        int e;
        p = '0;
        for (int k = 0; k < N; k++) begin
            e = v[k];
            p[DW*k +: DW] = e[DW-1:0];
        end
        return p;
    endfunction

    function automatic int res0();
        return int'($signed(bus0.result));
    endfunction

    function automatic int res1();
        return int'($signed(bus1.result));
    endfunction

    task automatic do_conv(input int im[N], input int fl[N], input int e0, input int e1,
                           input string nm);
        int  busy_cnt;
        int  lat;
        int  d1;
        bit  seen;
        @(negedge clk);
        tb_img   = pack(im);
        tb_flt   = pack(fl);
        tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        tb_img   = '0;
        tb_flt   = '0;
        busy_cnt = 0;
        lat      = 0;
        d1       = 0;
        seen     = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (bus0.done) begin
                seen = 1'b1;
                lat  = c;
                d1   = int'(bus1.done);
            end else if (bus0.busy) begin
                busy_cnt++;
            end
        end
        check({nm, "_busy_cycles"}, busy_cnt, N);
        check({nm, "_done_latency"}, lat - 1, N);
        check({nm, "_done1"}, d1, 1);
        check({nm, "_result0"}, res0(), e0);
        check({nm, "_result1"}, res1(), e1);
        @(negedge clk);
        check({nm, "_done_width"}, int'(bus0.done), 0);
        check({nm, "_busy_after"}, int'(bus0.busy), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   im[N];
        int   fl[N];
        int   ia[N];
        int   ib[N];
        int   fa[N];
        int   ea0[2];
        int   ea1[2];
        int   cnt;
        int   dones;
        int   hold_res;
        bit   got;

        tbl[0] = '{1, 1, 9, 2};
        tbl[1] = '{127, 127, 127, 127};
        tbl[3] = '{3, 1, 27, 6};
`ifdef CONV_RELU_EN
        tbl[2] = '{-1, 1, 0, 0};
        tbl[4] = '{-128, 127, 0, 0};
        tbl[5] = '{-3, 1, 0, 0};
`else
        tbl[2] = '{-1, 1, -9, -3};
        tbl[4] = '{-128, 127, -128, -128};
        tbl[5] = '{-3, 1, -27, -7};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus0.busy), 0);
        check("reset_done", int'(bus0.done), 0);
        check("reset_result0", res0(), 0);
        check("reset_result1", res1(), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) begin
                im[k] = tbl[i].iv;
                fl[k] = tbl[i].fv;
            end
            do_conv(im, fl, tbl[i].e0, tbl[i].e1, $sformatf("tbl%0d", i));
        end

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N; k++) begin
                im[k] = int'($urandom_range(0, 255)) - 128;
                fl[k] = int'($urandom_range(0, 255)) - 128;
            end
            if (r % 4 == 3) begin
                for (int k = 0; k < N; k++) fl[k] = fl[k] % 8;
            end
            do_conv(im, fl, ref_conv(im, fl, 0), ref_conv(im, fl, 2), $sformatf("rnd%0d", r));
        end

        // start re-pulsed mid-MAC must not restart or add a done.
        for (int k = 0; k < N; k++) begin
            im[k] = int'($urandom_range(0, 255)) - 128;
            fl[k] = int'($urandom_range(0, 15)) - 8;
            ia[k] = 1;
        end
        @(negedge clk);
        tb_img = pack(im); tb_flt = pack(fl); tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0; tb_img = '0; tb_flt = '0;
        dones = 0; hold_res = 999;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 4) begin
                tb_start = 1'b1; tb_img = pack(ia); tb_flt = pack(ia);
            end else if (c == 5) begin
                tb_start = 1'b0;
            end
            if (bus0.done) begin
                dones++;
                hold_res = res0();
            end
        end
        check("repulse_done_count", dones, 1);
        check("repulse_result", hold_res, ref_conv(im, fl, 0));

        // start held high: back-to-back convolutions on alternating operand sets.
        for (int k = 0; k < N; k++) begin
            ia[k] = 1;
            ib[k] = -1;
            fa[k] = 1;
        end
        ea0[0] = ref_conv(ia, fa, 0); ea1[0] = ref_conv(ia, fa, 2);
        ea0[1] = ref_conv(ib, fa, 0); ea1[1] = ref_conv(ib, fa, 2);
        @(negedge clk);
        tb_img = pack(ia); tb_flt = pack(fa); tb_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt = 0; got = 1'b0;
            while (!got && cnt < 30) begin
                @(negedge clk);
                cnt++;
                if (bus0.done) got = 1'b1;
            end
            check($sformatf("held%0d_seen", i), int'(got), 1);
            if (i > 0) check($sformatf("held%0d_period", i), cnt, N + 1);
            check($sformatf("held%0d_result0", i), res0(), ea0[i % 2]);
            check($sformatf("held%0d_result1", i), res1(), ea1[i % 2]);
            if (i == 2) begin
                tb_start = 1'b0;
            end else if (i % 2 == 0) begin
                tb_img = pack(ib);
            end else begin
                tb_img = pack(ia);
            end
        end
        repeat (2) @(negedge clk);
        check("held_idle_busy", int'(bus0.busy), 0);

        // Asynchronous reset in the middle of MAC.
        for (int k = 0; k < N; k++) begin
            im[k] = int'($urandom_range(0, 255)) - 128;
            fl[k] = int'($urandom_range(0, 255)) - 128;
        end
        @(negedge clk);
        tb_img = pack(im); tb_flt = pack(fl); tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        repeat (4) @(negedge clk);
        check("prereset_busy", int'(bus0.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_busy", int'(bus0.busy), 0);
        check("async_reset_done", int'(bus0.done), 0);
        check("async_reset_result0", res0(), 0);
        check("async_reset_result1", res1(), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus0.done || bus1.done) dones++;
        end
        check("post_reset_no_done", dones, 0);
        do_conv(im, fl, ref_conv(im, fl, 0), ref_conv(im, fl, 2), "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_mac_seq.md
Name: conv_mac_seq

Overview:
- Parametrised sequential convolution core. It computes one output pixel as the dot product of a D×F×F image window and a filter of the same size.
- A single signed multiply-accumulate stage processes one element per cycle.
- Adds a start/busy/done handshake, signed arithmetic, a wide accumulator, fixed-point rescale and output saturation.
- Sits between the window-extraction logic and the feature-map writer, one instance per output channel.

Parameters:
- DATA_WIDTH, 8: width of image, filter and result elements (signed two's complement).
- D, 1: filter depth (input channels).
- F, 3: filter height and width.
- ACC_WIDTH, 24: accumulator width. Must be ≥ 2*DATA_WIDTH + clog2(D*F*F).
- FRAC_BITS, 0: arithmetic right shift applied to the accumulator before saturation (fixed-point rescale).

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new convolution; sampled on the rising edge.
- image, input, [0:D*F*F*DATA_WIDTH-1]: window elements. Element k occupies bits DATA_WIDTH*k +: DATA_WIDTH, so element 0 is at the left (index 0) end.
- filter, input, [0:D*F*F*DATA_WIDTH-1]: filter weights, same packing as image.
- busy, output, 1: high while a convolution is in progress.
- done, output, 1: single-cycle pulse marking result valid.
- result, output, [0:DATA_WIDTH-1]: saturated output pixel. Held until the next done.

Behaviour:
- N = D*F*F.
- FSM states and transitions:
  - IDLE, DONE: a sampled start moves to MAC.
  - MAC: after N accumulate cycles, moves to DONE.
  - DONE: lasts one cycle, then moves to IDLE unless start is sampled.
- Reset (reset=0, any time, including mid-MAC):
  - state=IDLE, element index=0, accumulator=0.
  - Operand registers cleared.
  - busy=0, done=0, result=0.
  - An in-flight computation is discarded, with no done pulse.
- Start acceptance:
  - start is accepted only in IDLE or DONE; start during MAC is ignored.
  - On the accepting edge, image and filter are captured into internal registers. Input changes after that edge do not affect the result.
  - The same edge clears the accumulator, clears the index and enters MAC.
- MAC: on each edge, acc += sext(img[idx]) * sext(flt[idx]) with a signed full-precision product, then idx increments. Elements are processed in order 0..N-1.
- Final MAC edge (edge N after acceptance):
  - The final sum is arithmetic-shifted right by FRAC_BITS (truncation toward −inf).
  - The shifted value is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] and registered into result.
  - State becomes DONE.
- busy timing: high from the cycle after acceptance through the final MAC cycle. Low in IDLE and DONE.
- done: high exactly one cycle (the DONE state).
- Latency: done is high in the N-th cycle after the accepting edge (N=9 for defaults). Throughput: one result per N+1 cycles, back-to-back.
- Start asserted during DONE:
  - Begins the next convolution.
  - done still pulses for the current result.
  - result is not changed until the next final MAC edge.
- Accumulator overflow: none, by the ACC_WIDTH parameter rule. The bench checks the rule with an elaboration-time assertion.

Optional Feature:
- Macro CONV_RELU_EN.
- When defined: ReLU is applied after rescale and before saturation, so negative values produce result=0 and positives saturate as normal.
- When undefined: result is the signed saturated value. There is no port difference.

Test Plan:
- Defaults, image all 1, filter all 1, single start pulse:
  - busy high for 9 cycles, done pulses in cycle 9 after acceptance, result=9.
  - Inputs changed to 0 after acceptance do not alter the result.
- Image all 127, filter all 127: sum 145161 → result=127 (saturated high).
- Image all −1 (0xFF), filter all 1 → result=−9 (0xF7). With CONV_RELU_EN, result=0.
  - Image all −128, filter all 127 → result=−128.
- FRAC_BITS=2, image all 3, filter all 1: sum 27 → result=6. Image all −3: sum −27 → result=−7.
- start re-pulsed during MAC is ignored (a single done only). start held high continuously gives done every 10 cycles with correct results for alternating operand sets.
- reset asserted at MAC cycle 4 clears busy, done and result immediately (asynchronously), with no done pulse. A new start after release gives a correct result in 9 cycles.
